// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared types and helpers for the data-memory subsystem.
//   size_e      : access size encoding carried on req_size (2'b11 is illegal).
//   state_e     : response FSM states (IDLE, WAIT, RESP).
//   MMIO_WIN_MASK / HALT_OFFSET : decode of the MMIO window and halt register.
//   byte_enable / store_data / load_extend : lane steering for sub-word accesses.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // An address is inside the MMIO window when its masked value equals the base.
    localparam logic [31:0] MMIO_WIN_MASK = 32'hFFFF_FF00;
    localparam logic [7:0]  HALT_OFFSET   = 8'h00;

    // Byte enables for a store of the given size at byte lane 'lane'.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the LSB-aligned store data across every lane; the byte
    // enables then pick the lane that is actually written.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{wdata[7:0]}};
            SZ_HALF: d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Select the addressed byte/halfword from a whole word and extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = word >> {lane, 3'b000};
        case (size)
            SZ_BYTE: res = uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: res = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array -- DEPTH_WORDS x 32 RAM, byte-enable synchronous write,
// asynchronous read at the same word index.
//   clk   : clock
//   we    : write strobe (qualified by be)
//   be    : per-byte write enables
//   idx   : word index for both read and write
//   wdata : write data (lane-aligned)
//   rdata : combinational read data of word idx
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_subsys.sv
// dmem_subsys -- data-memory subsystem with valid/ready request handshake,
// configurable read latency, sub-word loads/stores, fault reporting and a
// sticky MMIO halt register.
//   clk, reset                : clock, synchronous active-high reset
//   req_valid / req_ready     : request handshake; accept = req_valid && req_ready
//   req_write, req_addr, req_wdata, req_size, req_unsigned : request fields,
//                               sampled only at the accept edge
//   rsp_valid                 : one-cycle response pulse
//   rsp_rdata, rsp_fault      : load data (0 for stores/faults) and fault flag
//   mmio_halt, mmio_halt_code : sticky halt flag and last written halt code
//
// Handshake: req_ready is high in every state except WAIT, so a new request
// can be accepted in the RESP cycle of the previous one. Every accepted
// request produces exactly one rsp_valid pulse unless reset intervenes.
module dmem_subsys
    import dmem_pkg::*;
#(
    parameter int          ADDR_W       = 32,
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              mmio_halt,
    output logic [31:0]       mmio_halt_code
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [2:0]  LAT_INIT = 3'(READ_LATENCY - 1);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(MMIO_BASE);
    localparam logic [ADDR_W-1:0] MASK_A = ADDR_W'(MMIO_WIN_MASK);
    localparam logic [ADDR_W-1:0] HALT_A = BASE_A | ADDR_W'(HALT_OFFSET);

    state_e      state, state_next;
    logic [2:0]  lat_cnt, lat_next;

    // Request captured at acceptance, held until its RESP cycle.
    logic        r_fault;
    logic        r_write;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic        r_uns;
    logic [31:0] r_word;

    logic        accept;
    logic        in_mmio;
    logic        is_halt;
    logic        out_of_range;
    logic        fault;
    logic        ram_we;
    logic [31:0] arr_rdata;

    // ---------------- decode ----------------
    assign req_ready    = (state != WAIT);
    assign accept       = req_valid && req_ready;
    assign in_mmio      = ((req_addr & MASK_A) == BASE_A);
    assign is_halt      = (req_addr == HALT_A);
    assign out_of_range = ((req_addr >> (IDX_W + 2)) != '0);

    always_comb begin
        fault = 1'b0;
        if (req_size == 2'b11)                                fault = 1'b1;
        if (req_size == SZ_HALF && req_addr[0])               fault = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)    fault = 1'b1;
        if (!in_mmio && out_of_range)                         fault = 1'b1;
        if (in_mmio && !is_halt)                              fault = 1'b1;
        if (is_halt && req_size != SZ_WORD)                   fault = 1'b1;
    end

    // RAM is written only by a legal, non-MMIO store; reset suppresses it so
    // a request presented during reset has no side effect.
    assign ram_we = accept && !reset && req_write && !fault && !in_mmio;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk  (clk),
        .we   (ram_we),
        .be   (byte_enable(req_size, req_addr[1:0])),
        .idx  (req_addr[IDX_W+1:2]),
        .wdata(store_data(req_size, req_wdata)),
        .rdata(arr_rdata)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_next;
            lat_cnt <= lat_next;
        end
    end

    always_comb begin
        state_next = state;
        lat_next   = lat_cnt;
        case (state)
            WAIT: begin
                if (lat_cnt == 3'd1) begin
                    state_next = RESP;
                end else begin
                    lat_next = lat_cnt - 3'd1;
                end
            end
            default: begin
                if (accept) begin
                    if (!req_write && !fault && READ_LATENCY > 1) begin
                        state_next = WAIT;
                        lat_next   = LAT_INIT;
                    end else begin
                        state_next = RESP;
                    end
                end else if (state == RESP) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // ---------------- capture and halt register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault        <= 1'b0;
            r_write        <= 1'b0;
            r_size         <= '0;
            r_lane         <= '0;
            r_uns          <= 1'b0;
            r_word         <= '0;
            mmio_halt      <= 1'b0;
            mmio_halt_code <= '0;
        end else if (accept) begin
            r_fault <= fault;
            r_write <= req_write;
            r_size  <= req_size;
            r_lane  <= req_addr[1:0];
            r_uns   <= req_unsigned;
            // Whole word is latched now; lane selection happens at RESP.
            r_word  <= is_halt ? mmio_halt_code : arr_rdata;
            if (req_write && !fault && is_halt) begin
                mmio_halt      <= 1'b1;
                mmio_halt_code <= req_wdata;
            end
        end
    end

    // ---------------- response ----------------
    assign rsp_valid = (state == RESP);
    assign rsp_fault = rsp_valid && r_fault;
    assign rsp_rdata = (rsp_valid && !r_fault && !r_write)
                       ? load_extend(r_word, r_size, r_lane, r_uns) : 32'h0;

endmodule
